blkmem_arbiter: RTL and testbench

BLKMEM_ARBITER -- requirements
Module: blkmem_arbiter

---
 rtl/blkmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_blkmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blkmem_arbiter.sv
// ----------------------------------------------------------------------------
// blkmem_arbiter
//   Two-master arbiter in front of a single block memory. Master 0 (CPU) and
//   master 1 (DMA/loader) issue Wishbone-style requests (cyc/stb/we). The
//   winner owns the memory for as long as it holds cyc; there is no
//   preemption. Contention seen from IDLE goes to the master that did not own
//   the memory last, giving round-robin fairness at release.
//
// Ports
//   i_clk, i_reset_n        single clock, asynchronous active-low reset
//   i_m0_* / o_m0_*         master 0 request (dat/addr/we/cyc/stb), data/ack
//   i_m1_* / o_m1_*         master 1 request, same widths as master 0
//   o_mem_*                 request forwarded to the block memory
//   i_mem_dat, i_mem_ack    block memory read data and acknowledge
//   o_grant                 one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
// ----------------------------------------------------------------------------
module blkmem_arbiter #(
   parameter int AW = 15
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   // master 0
   input  logic [15:0]   i_m0_dat,
   input  logic [AW-1:0] i_m0_addr,
   input  logic          i_m0_we,
   input  logic          i_m0_cyc,
   input  logic [1:0]    i_m0_stb,
   output logic [15:0]   o_m0_dat,
   output logic          o_m0_ack,
   // master 1
   input  logic [15:0]   i_m1_dat,
   input  logic [AW-1:0] i_m1_addr,
   input  logic          i_m1_we,
   input  logic          i_m1_cyc,
   input  logic [1:0]    i_m1_stb,
   output logic [15:0]   o_m1_dat,
   output logic          o_m1_ack,
   // block memory
   output logic [15:0]   o_mem_dat,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_we,
   output logic          o_mem_cyc,
   output logic [1:0]    o_mem_stb,
   input  logic [15:0]   i_mem_dat,
   input  logic          i_mem_ack,
   // status
   output logic [1:0]    o_grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state;
   state_t next_state;
   logic   last_owner;   // index of the master that most recently took ownership

   // -------------------------------------------------------------------------
   // State register. last_owner resets to 1 so master 0 wins the first
   // contention. Because every memory-side output is decoded from state, an
   // asynchronous reset kills any in-flight write immediately, with no clock.
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= next_state;
         // Re-writing the same index while an owner keeps cyc is harmless,
         // so updating on every cycle in OWNx is equivalent to "on entry".
         if (next_state == OWN0)
            last_owner <= 1'b0;
         else if (next_state == OWN1)
            last_owner <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic. Ownership changes only when the owner drops cyc; the
   // waiting master takes over on the very next edge without an idle cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: a default assignment ahead of the case keeps every path
      // assigned, so no latch is inferred for next_state.
      next_state = state;
      unique case (state)
         IDLE: begin
            if (i_m0_cyc && i_m1_cyc)
               next_state = last_owner ? OWN0 : OWN1;
            else if (i_m0_cyc)
               next_state = OWN0;
            else if (i_m1_cyc)
               next_state = OWN1;
         end
         OWN0: begin
            if (!i_m0_cyc)
               next_state = i_m1_cyc ? OWN1 : IDLE;
         end
         OWN1: begin
            if (!i_m1_cyc)
               next_state = i_m0_cyc ? OWN0 : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic. The owner's request is passed straight through; the
   // non-owner never reaches the memory and sees ack=0 (stall). o_mem_cyc
   // follows the owner's cyc, so it drops in the same cycle the owner
   // releases.
   // -------------------------------------------------------------------------
   always_comb begin
      o_mem_dat  = 16'h0000;
      o_mem_addr = '0;
      o_mem_we   = 1'b0;
      o_mem_cyc  = 1'b0;
      o_mem_stb  = 2'b00;
      o_m0_dat   = 16'h0000;
      o_m0_ack   = 1'b0;
      o_m1_dat   = 16'h0000;
      o_m1_ack   = 1'b0;
      o_grant    = 2'b00;
      unique case (state)
         OWN0: begin
            o_mem_dat  = i_m0_dat;
            o_mem_addr = i_m0_addr;
            o_mem_we   = i_m0_we;
            o_mem_cyc  = i_m0_cyc;
            o_mem_stb  = i_m0_stb;
            o_m0_dat   = i_mem_dat;
            o_m0_ack   = i_m0_cyc & i_mem_ack;
            o_grant    = 2'b01;
         end
         OWN1: begin
            o_mem_dat  = i_m1_dat;
            o_mem_addr = i_m1_addr;
            o_mem_we   = i_m1_we;
            o_mem_cyc  = i_m1_cyc;
            o_mem_stb  = i_m1_stb;
            o_m1_dat   = i_mem_dat;
            o_m1_ack   = i_m1_cyc & i_mem_ack;
            o_grant    = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_blkmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_blkmem_arbiter
//   Directed bench for blkmem_arbiter. A behavioural block memory with byte
//   lanes and a same-cycle ack sits behind the arbiter. Inputs change 1 time
//   unit after a rising edge; outputs are sampled a further 1 unit later, away
//   from the active edge.
// ----------------------------------------------------------------------------
module tb_blkmem_arbiter;

   localparam int AW = 15;

   logic          clk;
   logic          rst_n;
   logic [15:0]   m0_dat,  m1_dat;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          m0_we,   m1_we;
   logic          m0_cyc,  m1_cyc;
   logic [1:0]    m0_stb,  m1_stb;
   logic [15:0]   m0_rdat, m1_rdat;
   logic          m0_ack,  m1_ack;
   logic [15:0]   mem_wdat;
   logic [AW-1:0] mem_addr;
   logic          mem_we, mem_cyc;
   logic [1:0]    mem_stb;
   logic [15:0]   mem_rdat;
   logic          mem_ack;
   logic [1:0]    grant;

   int total  = 0;
   int passed = 0;

   blkmem_arbiter #(.AW(AW)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_m0_dat  (m0_dat),  .i_m0_addr (m0_addr), .i_m0_we (m0_we),
      .i_m0_cyc  (m0_cyc),  .i_m0_stb  (m0_stb),
      .o_m0_dat  (m0_rdat), .o_m0_ack  (m0_ack),
      .i_m1_dat  (m1_dat),  .i_m1_addr (m1_addr), .i_m1_we (m1_we),
      .i_m1_cyc  (m1_cyc),  .i_m1_stb  (m1_stb),
      .o_m1_dat  (m1_rdat), .o_m1_ack  (m1_ack),
      .o_mem_dat (mem_wdat), .o_mem_addr (mem_addr), .o_mem_we (mem_we),
      .o_mem_cyc (mem_cyc),  .o_mem_stb  (mem_stb),
      .i_mem_dat (mem_rdat), .i_mem_ack  (mem_ack),
      .o_grant   (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural block memory: combinational read, byte-lane write on edge.
   logic [15:0] tmem [0:(1<<AW)-1];
   assign mem_ack  = mem_cyc & (|mem_stb);
   assign mem_rdat = tmem[mem_addr];
   always @(posedge clk) begin
      if (mem_cyc && mem_we && mem_ack) begin
         if (mem_stb[0]) tmem[mem_addr][7:0]  <= mem_wdat[7:0];
         if (mem_stb[1]) tmem[mem_addr][15:8] <= mem_wdat[15:8];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m0(input logic cyc, input logic we, input logic [AW-1:0] addr,
                           input logic [15:0] dat, input logic [1:0] stb);
      m0_cyc = cyc; m0_we = we; m0_addr = addr; m0_dat = dat; m0_stb = stb;
   endtask

   task automatic drive_m1(input logic cyc, input logic we, input logic [AW-1:0] addr,
                           input logic [15:0] dat, input logic [1:0] stb);
      m1_cyc = cyc; m1_we = we; m1_addr = addr; m1_dat = dat; m1_stb = stb;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   // Reset state, and first arbitration on the first edge after release.
   task automatic test_reset();
      rst_n = 1'b0;
      drive_m0(1'b1, 1'b1, 15'h0005, 16'h5555, 2'b11);
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step(); step();
      total++; if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant); else passed++;
      total++; if (mem_cyc !== 1'b0) $display("FAIL reset_mem_cyc got=%b exp=0", mem_cyc); else passed++;
      total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else passed++;
      total++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL reset_acks got=%b exp=00", {m0_ack, m1_ack}); else passed++;
      total++; if (tmem[15'h0005] !== 16'h0000) $display("FAIL reset_no_write got=%h exp=0000", tmem[15'h0005]); else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (grant !== 2'b00) $display("FAIL release_pre_edge got=%b exp=00", grant); else passed++;
      step();
      total++; if (grant !== 2'b01) $display("FAIL release_first_grant got=%b exp=01", grant); else passed++;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   // Single master write then read back.
   task automatic test_single_master();
      drive_m0(1'b1, 1'b1, 15'h0010, 16'hBEEF, 2'b11);
      #1;
      total++; if (grant !== 2'b00) $display("FAIL single_idle_grant got=%b exp=00", grant); else passed++;
      total++; if (mem_cyc !== 1'b0) $display("FAIL single_idle_cyc got=%b exp=0", mem_cyc); else passed++;
      step();
      total++; if (grant !== 2'b01) $display("FAIL single_grant got=%b exp=01", grant); else passed++;
      total++; if (mem_we !== 1'b1) $display("FAIL single_we got=%b exp=1", mem_we); else passed++;
      total++; if (m0_ack !== 1'b1) $display("FAIL single_ack got=%b exp=1", m0_ack); else passed++;
      total++; if (mem_addr !== 15'h0010) $display("FAIL single_addr got=%h exp=0010", mem_addr); else passed++;
      step();
      drive_m0(1'b1, 1'b0, 15'h0010, 16'h0000, 2'b11);
      #1;
      total++; if (m0_rdat !== 16'hBEEF) $display("FAIL single_readback got=%h exp=BEEF", m0_rdat); else passed++;
      total++; if (m1_rdat !== 16'h0000) $display("FAIL single_nonowner_dat got=%h exp=0000", m1_rdat); else passed++;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      #1;
      total++; if (mem_cyc !== 1'b0) $display("FAIL single_release_cyc got=%b exp=0", mem_cyc); else passed++;
      step();
      total++; if (grant !== 2'b00) $display("FAIL single_back_idle got=%b exp=00", grant); else passed++;
   endtask

   // Contention from reset, handover without an idle cycle.
   task automatic test_contention();
      apply_reset();
      drive_m0(1'b1, 1'b0, 15'h0001, 16'h0000, 2'b11);
      drive_m1(1'b1, 1'b0, 15'h0002, 16'h0000, 2'b11);
      step();
      total++; if (grant !== 2'b01) $display("FAIL cont_first got=%b exp=01", grant); else passed++;
      total++; if (m1_ack !== 1'b0) $display("FAIL cont_m1_stall got=%b exp=0", m1_ack); else passed++;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      #1;
      total++; if (mem_cyc !== 1'b0) $display("FAIL cont_drop_cyc got=%b exp=0", mem_cyc); else passed++;
      step();
      total++; if (grant !== 2'b10) $display("FAIL cont_handover got=%b exp=10", grant); else passed++;
      total++; if (m1_ack !== 1'b1) $display("FAIL cont_m1_ack got=%b exp=1", m1_ack); else passed++;
      total++; if (mem_addr !== 15'h0002) $display("FAIL cont_m1_addr got=%h exp=0002", mem_addr); else passed++;
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   // Round-robin over three contentions, each released by both masters at once.
   task automatic test_round_robin();
      logic [1:0] exp_grant [3];
      exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive_m0(1'b1, 1'b0, 15'h0003, 16'h0000, 2'b11);
         drive_m1(1'b1, 1'b0, 15'h0004, 16'h0000, 2'b11);
         step();
         total++; if (grant !== exp_grant[i]) $display("FAIL rr_grant_%0d got=%b exp=%b", i, grant, exp_grant[i]); else passed++;
         drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
         drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
         step();
         total++; if (grant !== 2'b00) $display("FAIL rr_both_drop_%0d got=%b exp=00", i, grant); else passed++;
      end
   endtask

   // Owner drops and re-raises while the other waits: the other wins.
   task automatic test_reraise();
      apply_reset();
      drive_m0(1'b1, 1'b0, 15'h0006, 16'h0000, 2'b11);
      step();
      drive_m1(1'b1, 1'b0, 15'h0007, 16'h0000, 2'b11);
      step();
      total++; if (grant !== 2'b01) $display("FAIL reraise_hold got=%b exp=01", grant); else passed++;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
      drive_m0(1'b1, 1'b0, 15'h0006, 16'h0000, 2'b11);
      #1;
      total++; if (grant !== 2'b10) $display("FAIL reraise_other_wins got=%b exp=10", grant); else passed++;
      total++; if (m0_ack !== 1'b0) $display("FAIL reraise_m0_stall got=%b exp=0", m0_ack); else passed++;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   // Non-owner write is held off for 10 cycles, then lands once granted.
   task automatic test_stall_isolation();
      drive_m0(1'b1, 1'b0, 15'h0000, 16'h0000, 2'b11);
      step();
      drive_m1(1'b1, 1'b1, 15'h0020, 16'h1234, 2'b11);
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (m1_ack !== 1'b0) $display("FAIL stall_ack_%0d got=%b exp=0", i, m1_ack); else passed++;
         total++; if (mem_we !== 1'b0) $display("FAIL stall_we_%0d got=%b exp=0", i, mem_we); else passed++;
         total++; if (tmem[15'h0020] !== 16'h0000) $display("FAIL stall_mem_%0d got=%h exp=0000", i, tmem[15'h0020]); else passed++;
      end
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
      total++; if (grant !== 2'b10) $display("FAIL stall_grant got=%b exp=10", grant); else passed++;
      total++; if (m1_ack !== 1'b1) $display("FAIL stall_m1_ack got=%b exp=1", m1_ack); else passed++;
      total++; if (mem_addr !== 15'h0020) $display("FAIL stall_m1_addr got=%h exp=0020", mem_addr); else passed++;
      step();
      total++; if (tmem[15'h0020] !== 16'h1234) $display("FAIL stall_written got=%h exp=1234", tmem[15'h0020]); else passed++;
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   // Low byte lane only: AA55 over FFFF -> FF55.
   task automatic test_byte_lanes();
      drive_m1(1'b1, 1'b1, 15'h0030, 16'hFFFF, 2'b11);
      step();
      step();
      drive_m1(1'b1, 1'b1, 15'h0030, 16'hAA55, 2'b01);
      step();
      drive_m1(1'b1, 1'b0, 15'h0030, 16'h0000, 2'b11);
      #1;
      total++; if (m1_rdat !== 16'hFF55) $display("FAIL lanes_readback got=%h exp=FF55", m1_rdat); else passed++;
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   // Reset during an m1 write aborts it immediately and suppresses the write.
   task automatic test_reset_mid_transfer();
      drive_m1(1'b1, 1'b1, 15'h0040, 16'h1111, 2'b11);
      step();
      total++; if (mem_we !== 1'b1) $display("FAIL rmid_we_before got=%b exp=1", mem_we); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (grant !== 2'b00) $display("FAIL rmid_grant got=%b exp=00", grant); else passed++;
      total++; if (mem_we !== 1'b0) $display("FAIL rmid_we got=%b exp=0", mem_we); else passed++;
      total++; if (m1_ack !== 1'b0) $display("FAIL rmid_ack got=%b exp=0", m1_ack); else passed++;
      step();
      total++; if (tmem[15'h0040] !== 16'h0000) $display("FAIL rmid_no_write got=%h exp=0000", tmem[15'h0040]); else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (grant !== 2'b00) $display("FAIL rmid_release got=%b exp=00", grant); else passed++;
      step();
      total++; if (grant !== 2'b10) $display("FAIL rmid_regrant got=%b exp=10", grant); else passed++;
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      step();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) tmem[i] = 16'h0000;
      rst_n = 1'b0;
      drive_m0(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      drive_m1(1'b0, 1'b0, '0, 16'h0000, 2'b00);
      test_reset();
      test_single_master();
      test_contention();
      test_round_robin();
      test_reraise();
      test_stall_isolation();
      test_byte_lanes();
      test_reset_mid_transfer();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
